// File: rtl/dm_cache_unit.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// It runs its own miss and flush sequencing and keeps saturating hit/miss counters.
module dm_cache_unit #(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic             cpu_is_word,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  input  logic             flush,
  output logic             flush_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_REFILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB,
    S_FLUSH_END
  } state_t;

  state_t           state;
  logic             we_reg;
  logic             word_reg;
  logic             first_reg;
  logic [1:0]       off_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] scan_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      wdata_reg;
  logic [LINES-1:0] valid_reg;
  logic [LINES-1:0] dirty_reg;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             hit;
  logic [7:0]       lane;
  logic [31:0]      merged;
  logic             arr_we;
  logic [TAG_W-1:0] arr_tag;
  logic [31:0]      arr_data;

  // The flush walk reads the line under the scan pointer; everything else uses the request index.
  assign rd_idx    = (state == S_FLUSH_WB) ? scan_reg : idx_reg;
  assign line_tag  = tag_mem[rd_idx];
  assign line_data = data_mem[rd_idx];
  assign hit       = valid_reg[idx_reg] && (line_tag == tag_reg);

  always_comb begin
    lane = 8'h00;
    unique case (off_reg)
      2'd0: lane = line_data[31:24];
      2'd1: lane = line_data[23:16];
      2'd2: lane = line_data[15:8];
      2'd3: lane = line_data[7:0];
    endcase
  end

  always_comb begin
    merged = line_data;
    if (word_reg) begin
      merged = wdata_reg;
    end else begin
      unique case (off_reg)
        2'd0: merged[31:24] = wdata_reg[7:0];
        2'd1: merged[23:16] = wdata_reg[7:0];
        2'd2: merged[15:8]  = wdata_reg[7:0];
        2'd3: merged[7:0]   = wdata_reg[7:0];
      endcase
    end
  end

  // Line storage is written by a store hit or by a completed refill.
  always_comb begin
    arr_we   = 1'b0;
    arr_tag  = tag_reg;
    arr_data = merged;
    if (state == S_COMPARE && hit && we_reg) begin
      arr_we = 1'b1;
    end else if (state == S_REFILL && mem_req && mem_ack) begin
      arr_we   = 1'b1;
      arr_data = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[idx_reg]  <= arr_tag;
      data_mem[idx_reg] <= arr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      we_reg     <= 1'b0;
      word_reg   <= 1'b0;
      first_reg  <= 1'b0;
      off_reg    <= '0;
      idx_reg    <= '0;
      scan_reg   <= '0;
      tag_reg    <= '0;
      wdata_reg  <= '0;
      valid_reg  <= '0;
      dirty_reg  <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (flush) begin
            scan_reg <= '0;
            state    <= S_FLUSH_SCAN;
          end else if (cpu_req) begin
            we_reg    <= cpu_we;
            word_reg  <= cpu_is_word;
            off_reg   <= cpu_addr[1:0];
            idx_reg   <= cpu_addr[IDX_W+1:2];
            tag_reg   <= cpu_addr[31:IDX_W+2];
            wdata_reg <= cpu_wdata;
            first_reg <= 1'b1;
            state     <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          // Only the first look at a request is counted; the post-refill hit is not.
          if (first_reg) begin
            first_reg <= 1'b0;
            if (hit) begin
              if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
            end else begin
              if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
            end
          end
          if (hit) begin
            cpu_ready <= 1'b1;
            if (we_reg) begin
              dirty_reg[idx_reg] <= 1'b1;
            end else begin
              cpu_rdata <= word_reg ? line_data : {24'h0, lane};
            end
            state <= S_IDLE;
          end else if (valid_reg[idx_reg] && dirty_reg[idx_reg]) begin
            state <= S_WRITEBACK;
          end else begin
            state <= S_REFILL;
          end
        end

        S_WRITEBACK: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {line_tag, idx_reg, 2'b00};
            mem_wdata <= line_data;
          end else if (mem_ack) begin
            mem_req            <= 1'b0;
            dirty_reg[idx_reg] <= 1'b0;
            state              <= S_REFILL;
          end
        end

        S_REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag_reg, idx_reg, 2'b00};
          end else if (mem_ack) begin
            mem_req            <= 1'b0;
            valid_reg[idx_reg] <= 1'b1;
            dirty_reg[idx_reg] <= 1'b0;
            state              <= S_COMPARE;
          end
        end

        S_FLUSH_SCAN: begin
          if (valid_reg[scan_reg] && dirty_reg[scan_reg]) begin
            state <= S_FLUSH_WB;
          end else if (scan_reg == LAST_IDX) begin
            state <= S_FLUSH_END;
          end else begin
            scan_reg <= scan_reg + 1'b1;
          end
        end

        S_FLUSH_WB: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {line_tag, scan_reg, 2'b00};
            mem_wdata <= line_data;
          end else if (mem_ack) begin
            mem_req             <= 1'b0;
            dirty_reg[scan_reg] <= 1'b0;
            if (scan_reg == LAST_IDX) begin
              state <= S_FLUSH_END;
            end else begin
              scan_reg <= scan_reg + 1'b1;
              state    <= S_FLUSH_SCAN;
            end
          end
        end

        S_FLUSH_END: begin
          flush_done <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dm_cache_unit.md
# dm_cache_unit

Parametrised direct-mapped, write-back, write-allocate data cache with its own miss/flush state machine, sitting between the core's load/store path and data memory. It replaces the core-driven cache control (where the core's Controller sequenced valid/dirty updates) with a self-contained block. The block handles:
- a request/ready handshake to the core and a req/ack handshake to memory of arbitrary latency;
- word and big-endian byte accesses;
- a full-cache flush;
- hit/miss statistics.

## Interface
Parameters:
- LINES, 16: number of one-word lines; power of two, ≥2. IDX_W = log2(LINES).
- CNT_W, 16: width of the hit/miss counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_b  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  access request; held with stable operands until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_is_word  in  1  1 = word access, 0 = byte access.
- cpu_addr  in  32  byte address. Word accesses ignore [1:0].
- cpu_wdata  in  32  store data. A byte store uses [7:0].
- cpu_rdata  out  32  load result; valid while cpu_ready=1, held until the next completion.
- cpu_ready  out  1  one-cycle completion pulse.
- flush  in  1  request write-back of all dirty lines; level, sampled in IDLE.
- flush_done  out  1  one-cycle pulse when the flush completes.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write-back, 0 = refill.
- mem_addr  out  32  word-aligned address; [1:0]=0.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  refill data; valid while mem_ack=1.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

## Operation
Address split:
- index = cpu_addr[IDX_W+1:2]
- tag = cpu_addr[31:IDX_W+2]
- byte offset = cpu_addr[1:0]

Byte lanes are big-endian:
- offset 0 → data[31:24]
- offset 1 → data[23:16]
- offset 2 → data[15:8]
- offset 3 → data[7:0]
- A byte load zero-extends the selected lane into cpu_rdata[7:0].
- A byte store writes only the selected lane.

Per-line storage: valid, dirty, tag, data.

FSM states:
- **IDLE**
  - If flush=1 → FLUSH_SCAN with scan index 0. Flush has priority when flush and cpu_req are both high.
  - Else if cpu_req=1 → latch the operands, set first=1, go to COMPARE.
- **COMPARE**
  - A hit is valid && tag match.
  - If first=1, increment hit_count or miss_count (saturating), then clear first.
  - Hit: assert cpu_ready and go to IDLE. A load drives cpu_rdata. A store merges data and sets dirty.
  - Miss with a valid dirty victim → WRITEBACK.
  - Otherwise → REFILL.
- **WRITEBACK**
  - Drives mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data.
  - On mem_ack: clear dirty, go to REFILL.
- **REFILL**
  - Drives mem_req=1, mem_we=0, mem_addr={tag, index, 2'b00}.
  - On mem_ack: write mem_rdata, set valid=1, dirty=0, new tag; go to COMPARE. This COMPARE hits and is not counted again.
  - Word-store misses also refill (uniform allocate).
- **FLUSH_SCAN**
  - If line[scan] is valid && dirty → FLUSH_WB.
  - Else if scan = LINES-1 → FLUSH_END.
  - Else scan+1.
- **FLUSH_WB**
  - Write-back of line[scan], same signalling as WRITEBACK.
  - On mem_ack: clear dirty. If scan = LINES-1 → FLUSH_END, else scan+1 and → FLUSH_SCAN.
- **FLUSH_END**
  - Pulse flush_done, go to IDLE. Lines stay valid.

## Timing
- Reset (async, immediate):
  - state goes to IDLE; all valid/dirty bits clear.
  - cpu_ready, flush_done, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, cpu_rdata = 0; counters = 0.
  - A transaction in flight is abandoned; mem_req drops without waiting for ack.
- Outputs are registered or decoded from state only. There is no combinational path from any cpu_* input to any mem_* output.
- Hit latency:
  - cpu_req sampled high at edge N → cpu_ready high in the cycle after edge N+1.
  - A hit takes 2 cycles from cpu_req assertion.
- Miss latency:
  - Clean miss: hit latency + REFILL cycles (≥1).
  - Dirty miss: adds WRITEBACK cycles (≥1).
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from mem_req rise until the mem_ack cycle.
  - mem_req falls the cycle after ack; back-to-back WRITEBACK→REFILL re-raises it one cycle later.
  - mem_ack may arrive in the first mem_req cycle.
- The core must hold cpu_req until cpu_ready and drop it for at least the cycle after. cpu_req high in the cycle after cpu_ready is treated as a new request.
- Counters saturate at 2^CNT_W−1.

## Test plan
1. Reset, word load 0x0000_0040; memory acks 0xDEADBEEF after 3 cycles → one refill at mem_addr 0x40, cpu_rdata=0xDEADBEEF, miss_count=1. Repeat the load → cpu_ready 2 cycles after req, no mem_req, hit_count=1.
2. Byte loads at 0x41 and 0x43 after case 1 → cpu_rdata 0x0000_00AD and 0x0000_00EF; both hits.
3. Byte store 0x11 at 0x43, then word load 0x0000_0080 (same index 0) → write-back mem_we=1, addr 0x40, data 0xDEADBE11; then refill at 0x80; miss_count increments by 1 only.
4. Dirty lines at indices 1 and 5 (LINES=16); assert flush → exactly two write-backs, to index 1 then index 5, then a flush_done pulse. A second flush → no mem_req, flush_done within LINES+2 cycles.
5. flush and cpu_req high in the same IDLE cycle → the flush completes (flush_done) before the request's cpu_ready.
6. Assert rst_b low during REFILL with mem_req=1 → mem_req=0 in the same cycle. After release, a load to the same address misses again and the counters restart from 0.
